// File: rtl/gpo_pkg.sv
// Shared definitions for the timed GPO instruction path: entry layout,
// field positions and the dispatcher state encoding.
package gpo_pkg;

  localparam int TS_LSB    = 32;
  localparam int TS_MSB    = 95;
  localparam int DEST_LSB  = 96;
  localparam int COUNTER_W = 64;

  typedef struct packed {
    logic [31:0] upper;      // dest + upper payload
    logic [63:0] timestamp;
    logic [31:0] lower;
  } gpo_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_DATA,
    ST_HOLD
  } disp_state_t;

endpackage

// File: rtl/timestamp_counter.sv
// Free-running 64-bit timestamp counter with run enable and a synchronous
// clear that overrides run.
module timestamp_counter
  import gpo_pkg::*;
(
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 clear,
  output logic [COUNTER_W-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK100MHZ) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/timed_instruction_dispatcher.sv
// Pops timed entries from the instruction FIFO, holds each until the counter
// reaches its timestamp, then broadcasts it with a one-cycle strobe.
module timed_instruction_dispatcher
  import gpo_pkg::*;
#(
  parameter int unsigned FIFO_READ_LATENCY = 1
) (
  input  logic         CLK100MHZ,
  input  logic         reset,
  input  logic         run,
  input  logic         counter_clear,
  input  logic         error_clear,
  input  logic [127:0] fifo_dout,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  output logic [127:0] gpo_in,
  output logic         counter_matched,
  output logic [63:0]  counter_value,
  output logic         timestamp_error,
  output logic [127:0] timestamp_error_data,
  output logic [31:0]  dispatch_count
);

  disp_state_t state_q, state_d;
  gpo_entry_t  entry_q;
  logic        first_hold_q;
  logic [1:0]  wait_cnt_q;

  logic        ts_match, ts_late, data_ready;
  logic        pop_d;

  timestamp_counter u_counter (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .run       (run),
    .clear     (counter_clear),
    .count     (counter_value)
  );

  // Late is only judged on the first HOLD cycle, so a counter clear during
  // HOLD turns the entry into a future one rather than an error.
  assign ts_match   = (state_q == ST_HOLD) && (entry_q.timestamp == counter_value);
  assign ts_late    = (state_q == ST_HOLD) && first_hold_q &&
                      (entry_q.timestamp < counter_value);
  assign data_ready = (state_q == ST_WAIT_DATA) &&
                      (wait_cnt_q == 2'(FIFO_READ_LATENCY - 1));

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (!fifo_empty) state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_WAIT_DATA;
      ST_WAIT_DATA: if (data_ready) state_d = ST_HOLD;
      ST_HOLD:      if (ts_match || ts_late) state_d = fifo_empty ? ST_IDLE : ST_FETCH;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop_d = 1'b0;
    unique case (state_q)
      ST_IDLE: pop_d = !fifo_empty;
      ST_HOLD: pop_d = (ts_match || ts_late) && !fifo_empty;
      default: pop_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      fifo_rd_en           <= 1'b0;
      gpo_in               <= '0;
      counter_matched      <= 1'b0;
      timestamp_error      <= 1'b0;
      timestamp_error_data <= '0;
      dispatch_count       <= '0;
      entry_q              <= '0;
      first_hold_q         <= 1'b0;
      wait_cnt_q           <= '0;
    end else begin
      fifo_rd_en      <= pop_d;
      counter_matched <= ts_match;
      first_hold_q    <= data_ready;
      wait_cnt_q      <= (state_q == ST_WAIT_DATA) ? wait_cnt_q + 1'b1 : 2'd0;

      if (data_ready) begin
        entry_q <= fifo_dout;
      end

      if (ts_match) begin
        gpo_in         <= entry_q;
        dispatch_count <= dispatch_count + 32'd1;
      end

      // A late event wins over a coincident clear and recaptures the data.
      if (ts_late) begin
        timestamp_error <= 1'b1;
        if (!timestamp_error || error_clear) begin
          timestamp_error_data <= entry_q;
        end
      end else if (error_clear) begin
        timestamp_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timed_instruction_dispatcher.sv
// Directed bench: instance 0 uses FIFO read latency 1, instance 1 latency 2,
// each fed by its own FIFO model; inputs change and outputs are sampled on negedge.
module tb_timed_instruction_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, run, counter_clear, error_clear;

  logic [127:0] fifo_mem [2][16];
  int           wr_ptr [2];
  int           rd_ptr [2];
  logic         fifo_empty [2];
  logic [127:0] dout1 [2];
  logic [127:0] dout2 [2];

  logic         rd_en [2];
  logic [127:0] gpo_in [2];
  logic         matched [2];
  logic [63:0]  counter_value [2];
  logic         ts_err [2];
  logic [127:0] ts_err_data [2];
  logic [31:0]  disp_cnt [2];

  int checks = 0;
  int errors = 0;

  initial begin
    wr_ptr[0] = 0; wr_ptr[1] = 0;
    rd_ptr[0] = 0; rd_ptr[1] = 0;
  end

  assign fifo_empty[0] = (wr_ptr[0] == rd_ptr[0]);
  assign fifo_empty[1] = (wr_ptr[1] == rd_ptr[1]);

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k]) begin
        dout1[k]  <= fifo_mem[k][rd_ptr[k] % 16];
        rd_ptr[k] <= rd_ptr[k] + 1;
      end
      dout2[k] <= dout1[k];
    end
  end

  timed_instruction_dispatcher #(.FIFO_READ_LATENCY(1)) dut0 (
    .CLK100MHZ            (clk),
    .reset                (reset),
    .run                  (run),
    .counter_clear        (counter_clear),
    .error_clear          (error_clear),
    .fifo_dout            (dout1[0]),
    .fifo_empty           (fifo_empty[0]),
    .fifo_rd_en           (rd_en[0]),
    .gpo_in               (gpo_in[0]),
    .counter_matched      (matched[0]),
    .counter_value        (counter_value[0]),
    .timestamp_error      (ts_err[0]),
    .timestamp_error_data (ts_err_data[0]),
    .dispatch_count       (disp_cnt[0])
  );

  timed_instruction_dispatcher #(.FIFO_READ_LATENCY(2)) dut1 (
    .CLK100MHZ            (clk),
    .reset                (reset),
    .run                  (run),
    .counter_clear        (counter_clear),
    .error_clear          (error_clear),
    .fifo_dout            (dout2[1]),
    .fifo_empty           (fifo_empty[1]),
    .fifo_rd_en           (rd_en[1]),
    .gpo_in               (gpo_in[1]),
    .counter_matched      (matched[1]),
    .counter_value        (counter_value[1]),
    .timestamp_error      (ts_err[1]),
    .timestamp_error_data (ts_err_data[1]),
    .dispatch_count       (disp_cnt[1])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [127:0] mk(input logic [31:0] up, input logic [63:0] ts,
                                      input logic [31:0] lo);
    return {up, ts, lo};
  endfunction

  task automatic push(input int k, input logic [127:0] e);
    fifo_mem[k][wr_ptr[k] % 16] = e;
    wr_ptr[k] = wr_ptr[k] + 1;
  endtask

  task automatic wait_strobe(input string tag, input int k, input int budget, output int n);
    n = 0;
    while (!matched[k] && n < budget) begin
      step();
      n++;
    end
    check(tag, 128'(matched[k]), 128'd1);
  endtask

  task automatic wait_count(input string tag, input logic [63:0] target, input int budget);
    int n = 0;
    while (counter_value[0] != target && n < budget) begin
      step();
      n++;
    end
    check(tag, 128'(counter_value[0]), 128'(target));
  endtask

  task automatic run_cycles(input int k, input int n, output int strobes);
    strobes = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (matched[k]) strobes++;
    end
  endtask

  task automatic check_zero(input string tag, input int k);
    check({tag, "_rd_en"},   128'(rd_en[k]), 128'd0);
    check({tag, "_gpo_in"},  gpo_in[k], 128'd0);
    check({tag, "_matched"}, 128'(matched[k]), 128'd0);
    check({tag, "_counter"}, 128'(counter_value[k]), 128'd0);
    check({tag, "_err"},     128'(ts_err[k]), 128'd0);
    check({tag, "_err_data"}, ts_err_data[k], 128'd0);
    check({tag, "_count"},   128'(disp_cnt[k]), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] e1, e200, e203, e205, e5, e6, e8, e9, e1000, e500, e40, f200, f204, f207;
    int n, s;

    e1    = mk(32'h0000_0005, 64'd100,  32'hA5A5_A5A5);
    e200  = mk(32'h0000_0001, 64'd200,  32'h1111_0000);
    e203  = mk(32'h0000_0002, 64'd203,  32'h2222_0000);
    e205  = mk(32'h0000_0003, 64'd205,  32'h3333_0000);
    e5    = mk(32'h0000_0004, 64'd5,    32'h5555_0005);
    e6    = mk(32'h0000_0006, 64'd6,    32'h6666_0006);
    e8    = mk(32'h0000_0008, 64'd8,    32'h8888_0008);
    e9    = mk(32'h0000_0009, 64'd9,    32'h9999_0009);
    e1000 = mk(32'h0000_000A, 64'd1000, 32'hDEAD_BEEF);
    e500  = mk(32'h0000_000B, 64'd500,  32'hBAD0_0500);
    e40   = mk(32'h0000_000C, 64'd40,   32'h4040_4040);
    f200  = mk(32'h0000_0011, 64'd200,  32'hF200_0000);
    f204  = mk(32'h0000_0012, 64'd204,  32'hF204_0000);
    f207  = mk(32'h0000_0013, 64'd207,  32'hF207_0000);

    reset = 1'b1; run = 1'b0; counter_clear = 1'b0; error_clear = 1'b0;
    step(); step(); step();
    check_zero("reset0", 0);
    check_zero("reset1", 1);
    reset = 1'b0;

    // Single dispatch
    push(0, e1);
    step();
    check("pop_after_empty_falls", 128'(rd_en[0]), 128'd1);
    step();
    check("pop_one_cycle", 128'(rd_en[0]), 128'd0);
    run = 1'b1;
    wait_strobe("single_strobe", 0, 200, n);
    check("single_counter", 128'(counter_value[0]), 128'd101);
    check("single_gpo", gpo_in[0], e1);
    check("single_count", 128'(disp_cnt[0]), 128'd1);
    step();
    check("strobe_width", 128'(matched[0]), 128'd0);
    check("gpo_held", gpo_in[0], e1);

    // Back-to-back at latency 1, clear has priority over run
    counter_clear = 1'b1;
    step();
    counter_clear = 1'b0;
    check("clear_priority", 128'(counter_value[0]), 128'd0);
    push(0, e200); push(0, e203); push(0, e205);
    wait_strobe("b2b_strobe1", 0, 300, n);
    check("b2b_counter1", 128'(counter_value[0]), 128'd201);
    check("b2b_gpo1", gpo_in[0], e200);
    step();
    wait_strobe("b2b_strobe2", 0, 20, n);
    check("b2b_counter2", 128'(counter_value[0]), 128'd204);
    check("b2b_gpo2", gpo_in[0], e203);
    run_cycles(0, 8, s);
    check("b2b_late_no_strobe", 128'(s), 128'd0);
    check("b2b_err", 128'(ts_err[0]), 128'd1);
    check("b2b_err_data", ts_err_data[0], e205);
    check("b2b_count", 128'(disp_cnt[0]), 128'd3);

    // Sticky error and clear
    error_clear = 1'b1;
    step();
    error_clear = 1'b0;
    check("clr_flag", 128'(ts_err[0]), 128'd0);
    check("clr_data_kept", ts_err_data[0], e205);
    push(0, e5); push(0, e6);
    run_cycles(0, 12, s);
    check("late2_no_strobe", 128'(s), 128'd0);
    check("late2_flag", 128'(ts_err[0]), 128'd1);
    check("late2_first_data", ts_err_data[0], e5);
    check("late2_count", 128'(disp_cnt[0]), 128'd3);
    error_clear = 1'b1;
    step();
    error_clear = 1'b0;
    check("clr2_flag", 128'(ts_err[0]), 128'd0);
    check("clr2_data_kept", ts_err_data[0], e5);
    push(0, e8);
    run_cycles(0, 6, s);
    check("late8_data", ts_err_data[0], e8);
    push(0, e9);
    step(); step(); step();
    error_clear = 1'b1;
    step();
    error_clear = 1'b0;
    check("coincide_flag", 128'(ts_err[0]), 128'd1);
    check("coincide_data", ts_err_data[0], e9);

    // Stall and counter clear during hold
    error_clear = 1'b1;
    step();
    error_clear = 1'b0;
    push(0, e1000);
    counter_clear = 1'b1;
    step();
    counter_clear = 1'b0;
    wait_count("reach_990", 64'd990, 1100);
    run = 1'b0;
    run_cycles(0, 20, s);
    check("stall_no_strobe", 128'(s), 128'd0);
    check("stall_counter", 128'(counter_value[0]), 128'd990);
    run = 1'b1;
    wait_count("reach_995", 64'd995, 20);
    counter_clear = 1'b1;
    step();
    counter_clear = 1'b0;
    check("hold_clear_counter", 128'(counter_value[0]), 128'd0);
    wait_strobe("hold_clear_strobe", 0, 1100, n);
    check("hold_clear_delay", 128'(n), 128'd1001);
    check("hold_clear_gpo", gpo_in[0], e1000);
    check("hold_clear_no_err", 128'(ts_err[0]), 128'd0);
    check("hold_clear_count", 128'(disp_cnt[0]), 128'd4);

    // Reset mid-hold
    push(0, e500);
    counter_clear = 1'b1;
    step();
    counter_clear = 1'b0;
    wait_count("reach_480", 64'd480, 600);
    reset = 1'b1;
    step();
    check_zero("midreset", 0);
    reset = 1'b0;
    push(0, e40);
    wait_strobe("post_reset_strobe", 0, 100, n);
    check("post_reset_counter", 128'(counter_value[0]), 128'd41);
    check("post_reset_gpo", gpo_in[0], e40);
    check("post_reset_count", 128'(disp_cnt[0]), 128'd1);
    run_cycles(0, 470, s);
    check("no_strobe_at_500", 128'(s), 128'd0);

    // Back-to-back at latency 2: spacing 4 dispatches, t+3 is late
    run = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    push(1, f200); push(1, f204); push(1, f207);
    run = 1'b1;
    wait_strobe("lat2_strobe1", 1, 300, n);
    check("lat2_counter1", 128'(counter_value[1]), 128'd201);
    check("lat2_gpo1", gpo_in[1], f200);
    step();
    wait_strobe("lat2_strobe2", 1, 20, n);
    check("lat2_counter2", 128'(counter_value[1]), 128'd205);
    check("lat2_gpo2", gpo_in[1], f204);
    run_cycles(1, 10, s);
    check("lat2_late_no_strobe", 128'(s), 128'd0);
    check("lat2_err", 128'(ts_err[1]), 128'd1);
    check("lat2_err_data", ts_err_data[1], f207);
    check("lat2_count", 128'(disp_cnt[1]), 128'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timed_instruction_dispatcher.md
# timed_instruction_dispatcher

- Feeds timed output instructions to the gpo core bank: pops 128-bit entries from the instruction FIFO and holds each until the 64-bit timestamp counter reaches its timestamp field.
- Then broadcasts the entry on `gpo_in` with a one-cycle `counter_matched` strobe, which every core qualifies with its own destination field.
- Entries already in the past when they reach the hold stage are dropped and reported as timestamp errors.
- Sits between the instruction FIFO read port and the shared `gpo_in`/`counter_matched` bus.

## Interface
- `FIFO_READ_LATENCY`, 1: cycles from `fifo_rd_en` to valid `fifo_dout`; legal values are 1 and 2.
- `CLK100MHZ` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `run` in 1: counter increments while high.
- `counter_clear` in 1: synchronous counter zero, one cycle.
- `error_clear` in 1: clears the sticky timestamp error.
- `fifo_dout` in 128: FIFO read data. Bits [127:96] are dest/upper payload, [95:32] are the timestamp, [31:0] are the lower payload.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO pop, one-cycle pulse.
- `gpo_in` out 128: broadcast entry to the cores.
- `counter_matched` out 1: one-cycle dispatch strobe.
- `counter_value` out 64: current counter.
- `timestamp_error` out 1: sticky late-entry flag.
- `timestamp_error_data` out 128: the first late entry since the last clear.
- `dispatch_count` out 32: number of entries dispatched, wraps modulo 2^32.

## Operation
- Counter:
  - `counter_clear` has priority over `run`.
  - Counter increments by 1 per cycle while `run`=1.
  - Wraps 2^64-1 → 0.
- FSM states: IDLE, FETCH, WAIT_DATA, HOLD.
- IDLE: if `fifo_empty`=0, assert `fifo_rd_en` for one cycle and go to FETCH.
- FETCH/WAIT_DATA: wait `FIFO_READ_LATENCY` cycles in total, then latch `fifo_dout` into the entry register and go to HOLD.
- HOLD, evaluated every cycle against the current `counter_value` (ts = entry[95:32]):
  - ts == counter: register `gpo_in`←entry and `counter_matched`=1 on the next edge; increment `dispatch_count`. If `fifo_empty`=0, pulse `fifo_rd_en` on that same edge and go to FETCH; otherwise go to IDLE.
  - ts < counter (unsigned), first HOLD cycle only: the entry is late. Drop it with no strobe. Set `timestamp_error`. Capture the entry into `timestamp_error_data` only if `timestamp_error` was 0. Then refetch or go IDLE, exactly as on a match.
  - Otherwise: stay in HOLD. Stalling `run` while in HOLD simply extends the hold.
- Match and late are mutually exclusive.
- `error_clear` clears the flag but not the data. If `error_clear` coincides with a late event, the error is set and the new data is captured.
- `counter_clear` while in HOLD: the entry keeps waiting for its (now future) timestamp and is not flagged late.
- `gpo_in` holds the last dispatched entry between strobes.

## Timing
- Reset values:
  - all outputs 0 (`fifo_rd_en`, `gpo_in`, `counter_matched`, `counter_value`, `timestamp_error`, `timestamp_error_data`, `dispatch_count`);
  - FSM in IDLE, entry register 0.
- Dispatch latency: counter == ts in cycle N gives `counter_matched`/`gpo_in` valid in cycle N+1.
- The strobe is exactly one cycle. There is no backpressure: the cores report busy conflicts themselves.
- Minimum back-to-back spacing at latency 1 is 3 ticks: entries with ts = t and t+3 both dispatch, with strobes 3 cycles apart. An entry with ts = t+2 is flagged late.
- FIFO-empty to first pop: 1 cycle after `fifo_empty` falls while in IDLE.
- Reset mid-operation: the held or in-flight entry is discarded; an entry already popped from the FIFO is lost.

## Structure
- Shared package `gpo_pkg`:
  - field constants `TS_LSB`=32, `TS_MSB`=95, `DEST_LSB`=96;
  - `gpo_entry_t` (128-bit packed struct: upper, timestamp, lower);
  - dispatcher state enum.
- One sub-module, `timestamp_counter`: the 64-bit counter with `run`/`clear`, instantiated here and reusable by other timed blocks.
- FSM, entry register, and error capture live in the top module.

## Test plan
- Single dispatch: FIFO holds {upper 0x0000_0005, ts 100, lower 0xA5A5_A5A5}; `run` from counter 0 → `fifo_rd_en` pulses once; `counter_matched`=1 only in the cycle after counter==100; `gpo_in` equals the entry; `dispatch_count`=1.
- Back-to-back: entries with ts 200, 203, 205 → strobes at counter 201 and 204; third entry late; `timestamp_error`=1; `timestamp_error_data` holds the ts-205 entry; `dispatch_count`=2.
- Sticky error and clear:
  - two late entries (ts 5, 6 with counter at 50) → error data holds the ts-5 entry;
  - `error_clear` → flag 0, data unchanged;
  - a late entry coincident with `error_clear` → flag 1, new data captured.
- Stall and clear: entry with ts 1000 held; `run` low for 20 cycles near counter 990 → strobe delayed accordingly; `counter_clear` at 995 → no error; strobe when the counter next reaches 1000.
- Reset mid-hold: reset asserted during HOLD with ts 500 → all outputs 0 the next cycle; no strobe at 500; the next FIFO entry is fetched normally after reset.
- `FIFO_READ_LATENCY`=2: repeat the back-to-back case → minimum spacing becomes 4; ts 200/204 both dispatch.
